// File: rtl/tlu_trigger_fifo_if.sv
// rtl/tlu_trigger_fifo_if.sv - readout-side FIFO interface of the TLU trigger data stage
interface tlu_trigger_fifo_if #(
    parameter int ADDR_W = 10
);
    logic              FIFO_READ;
    logic              FIFO_EMPTY;
    logic              FIFO_FULL;
    logic [31:0]       FIFO_DATA;
    logic [ADDR_W:0]   FIFO_SIZE;

    modport master (
        input  FIFO_READ,
        output FIFO_EMPTY, FIFO_FULL, FIFO_DATA, FIFO_SIZE
    );

    modport slave (
        output FIFO_READ,
        input  FIFO_EMPTY, FIFO_FULL, FIFO_DATA, FIFO_SIZE
    );
endinterface

// File: rtl/tlu_trigger_fifo.sv
// rtl/tlu_trigger_fifo.sv - trigger event serializer into FWFT word FIFO; TLU_TRIGGER_FIFO_DIAG_WORD_EN adds diagnostic word W3
module tlu_trigger_fifo #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic                CLK40,
    input  logic                RST_N,
    input  logic                CLEAR,
    input  logic                ENABLE,
    input  logic                TRIG,
    input  logic [31:0]         TRIG_ID,
    input  logic [63:0]         TIME_STAMP,
    input  logic [7:0]          LE_DISTANCE,
    input  logic [7:0]          SKIP_CNT,
    tlu_trigger_fifo_if.master  rd,
    output logic [7:0]          LOST_CNT,
    output logic                BUSY
);
`ifdef TLU_TRIGGER_FIFO_DIAG_WORD_EN
    typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_W3} state_t;
    localparam state_t S_LAST = S_W3;
    logic [7:0] ev_le_q, ev_skip_q, hold_le_q, hold_skip_q;
    logic       unused_ok;
    assign unused_ok = TRIG_ID[31];
`else
    typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2} state_t;
    localparam state_t S_LAST = S_W2;
    logic unused_ok;
    assign unused_ok = ^{TRIG_ID[31], LE_DISTANCE, SKIP_CNT};
`endif

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_t              state_q;
    logic [30:0]         ev_id_q, hold_id_q;
    logic [63:0]         ev_ts_q, hold_ts_q;
    logic                hold_vld_q;
    logic [7:0]          lost_q;
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic [31:0]         mem [DEPTH];
    logic [31:0]         wdata;

    logic empty, full, pop, wr_en, last_wr, accept, hold_xfer;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = rd.FIFO_READ && !empty && !CLEAR;
    // A pop frees a slot in the same edge, so a stalled word may land even while full.
    assign wr_en     = (state_q != S_IDLE) && (!full || pop) && !CLEAR;
    assign last_wr   = wr_en && (state_q == S_LAST);
    assign accept    = TRIG && ENABLE && !CLEAR;
    assign hold_xfer = hold_vld_q && ((state_q == S_IDLE) || last_wr);

    always_comb begin
        wdata = {1'b1, ev_id_q};
        case (state_q)
            S_W1:    wdata = ev_ts_q[31:0];
            S_W2:    wdata = ev_ts_q[63:32];
`ifdef TLU_TRIGGER_FIFO_DIAG_WORD_EN
            S_W3:    wdata = {8'hA5, 8'h00, ev_skip_q, ev_le_q};
`endif
            default: wdata = {1'b1, ev_id_q};
        endcase
    end

    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            ev_id_q    <= '0;
            ev_ts_q    <= '0;
            hold_id_q  <= '0;
            hold_ts_q  <= '0;
            hold_vld_q <= 1'b0;
            lost_q     <= '0;
`ifdef TLU_TRIGGER_FIFO_DIAG_WORD_EN
            ev_le_q     <= '0;
            ev_skip_q   <= '0;
            hold_le_q   <= '0;
            hold_skip_q <= '0;
`endif
        end else if (CLEAR) begin
            state_q    <= S_IDLE;
            hold_vld_q <= 1'b0;
            lost_q     <= '0;
        end else begin
            if (hold_xfer) begin
                ev_id_q <= hold_id_q;
                ev_ts_q <= hold_ts_q;
`ifdef TLU_TRIGGER_FIFO_DIAG_WORD_EN
                ev_le_q   <= hold_le_q;
                ev_skip_q <= hold_skip_q;
`endif
                state_q <= S_W0;
            end else if (state_q == S_IDLE && accept) begin
                ev_id_q <= TRIG_ID[30:0];
                ev_ts_q <= TIME_STAMP;
`ifdef TLU_TRIGGER_FIFO_DIAG_WORD_EN
                ev_le_q   <= LE_DISTANCE;
                ev_skip_q <= SKIP_CNT;
`endif
                state_q <= S_W0;
            end else if (wr_en) begin
                case (state_q)
                    S_W0:    state_q <= S_W1;
                    S_W1:    state_q <= S_W2;
`ifdef TLU_TRIGGER_FIFO_DIAG_WORD_EN
                    S_W2:    state_q <= S_W3;
`endif
                    default: state_q <= S_IDLE;
                endcase
            end

            // Busy serializer (or a pending holding transfer) routes new triggers to holding.
            if (accept && (state_q != S_IDLE || hold_vld_q)) begin
                if (!hold_vld_q || hold_xfer) begin
                    hold_id_q  <= TRIG_ID[30:0];
                    hold_ts_q  <= TIME_STAMP;
`ifdef TLU_TRIGGER_FIFO_DIAG_WORD_EN
                    hold_le_q   <= LE_DISTANCE;
                    hold_skip_q <= SKIP_CNT;
`endif
                    hold_vld_q <= 1'b1;
                end else if (lost_q != 8'hFF) begin
                    lost_q <= lost_q + 8'd1;
                end
            end else if (hold_xfer) begin
                hold_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (CLEAR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (ADDR_W + 1)'(wr_en) - (ADDR_W + 1)'(pop);
        end
    end

    always_ff @(posedge CLK40) begin
        if (wr_en) mem[wr_ptr_q] <= wdata;
    end

    assign rd.FIFO_EMPTY = empty;
    assign rd.FIFO_FULL  = full;
    assign rd.FIFO_SIZE  = count_q;
    assign rd.FIFO_DATA  = empty ? 32'h0 : mem[rd_ptr_q];
    assign LOST_CNT      = lost_q;
    assign BUSY          = (state_q != S_IDLE) || hold_vld_q;
endmodule

// File: tb/tb_tlu_trigger_fifo.sv
// tb/tb_tlu_trigger_fifo.sv - directed self-checking bench for tlu_trigger_fifo (DEPTH=8)
module tb_tlu_trigger_fifo;
`ifdef TLU_TRIGGER_FIFO_DIAG_WORD_EN
    localparam int WPE = 4;
`else
    localparam int WPE = 3;
`endif

    logic        CLK40 = 1'b0;
    logic        RST_N = 1'b0;
    logic        CLEAR = 1'b0;
    logic        ENABLE = 1'b1;
    logic        TRIG = 1'b0;
    logic [31:0] TRIG_ID = '0;
    logic [63:0] TIME_STAMP = '0;
    logic [7:0]  LE_DISTANCE = 8'h03;
    logic [7:0]  SKIP_CNT = 8'h02;
    logic [7:0]  LOST_CNT;
    logic        BUSY;

    int ncmp = 0;
    int nerr = 0;
    logic [31:0] exp_q[$];

    tlu_trigger_fifo_if #(.ADDR_W(3)) rd_if ();

    tlu_trigger_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
        .CLK40(CLK40), .RST_N(RST_N), .CLEAR(CLEAR), .ENABLE(ENABLE), .TRIG(TRIG),
        .TRIG_ID(TRIG_ID), .TIME_STAMP(TIME_STAMP), .LE_DISTANCE(LE_DISTANCE),
        .SKIP_CNT(SKIP_CNT), .rd(rd_if), .LOST_CNT(LOST_CNT), .BUSY(BUSY)
    );

    always #5 CLK40 = ~CLK40;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK40);
        #1;
    endtask

    task automatic rd_word(input string tag, input logic [31:0] exp);
        chk(tag, rd_if.FIFO_DATA, exp);
        rd_if.FIFO_READ = 1'b1;
        step();
        rd_if.FIFO_READ = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] id, input logic [63:0] ts);
        exp_q.push_back({1'b1, id[30:0]});
        exp_q.push_back(ts[31:0]);
        exp_q.push_back(ts[63:32]);
        if (WPE == 4) exp_q.push_back(32'hA500_0203);
    endtask

    task automatic fire(input logic [31:0] id, input logic [63:0] ts);
        TRIG = 1'b1;
        TRIG_ID = id;
        TIME_STAMP = ts;
        step();
        TRIG = 1'b0;
    endtask

    initial begin
        rd_if.FIFO_READ = 1'b0;
        #23;
        chk("rst_empty", rd_if.FIFO_EMPTY, 1);
        chk("rst_full", rd_if.FIFO_FULL, 0);
        chk("rst_size", rd_if.FIFO_SIZE, 0);
        chk("rst_data", rd_if.FIFO_DATA, 0);
        chk("rst_lost", LOST_CNT, 0);
        chk("rst_busy", BUSY, 0);
        RST_N = 1'b1;
        step(2);

        // single trigger
        exp_q.delete();
        push_exp(32'h5, 64'h0000_0001_0000_00A0);
        fire(32'h5, 64'h0000_0001_0000_00A0);
        chk("single_empty_e0", rd_if.FIFO_EMPTY, 1);
        step();
        chk("single_empty_e1", rd_if.FIFO_EMPTY, 0);
        chk("single_w0_head", rd_if.FIFO_DATA, 32'h8000_0005);
        step(WPE);
        chk("single_size", rd_if.FIFO_SIZE, WPE);
        for (int i = 0; i < WPE; i++) rd_word($sformatf("single_w%0d", i), exp_q[i]);
        chk("single_size_end", rd_if.FIFO_SIZE, 0);
        chk("single_empty_end", rd_if.FIFO_EMPTY, 1);

        // burst of three back-to-back triggers
        exp_q.delete();
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) push_exp(i, {32'h1000_0000 + i, 32'h2000_0000 + i});
            TRIG = 1'b1;
            TRIG_ID = i;
            TIME_STAMP = {32'h1000_0000 + i, 32'h2000_0000 + i};
            step();
        end
        TRIG = 1'b0;
        step(2 * WPE + 2);
        chk("burst_lost", LOST_CNT, 1);
        chk("burst_size", rd_if.FIFO_SIZE, 2 * WPE);
        chk("burst_busy", BUSY, 0);
        for (int i = 0; i < 2 * WPE; i++) rd_word($sformatf("burst_w%0d", i), exp_q[i]);
        chk("burst_empty_end", rd_if.FIFO_EMPTY, 1);

        // ENABLE low: triggers ignored and not counted
        ENABLE = 1'b0;
        TRIG = 1'b1;
        step(5);
        TRIG = 1'b0;
        ENABLE = 1'b1;
        step(2);
        chk("dis_empty", rd_if.FIFO_EMPTY, 1);
        chk("dis_lost", LOST_CNT, 1);
        chk("dis_busy", BUSY, 0);

        // CLEAR while in W1, with a TRIG in the same cycle
        fire(32'h7, 64'h7);
        step();
        chk("clr_pre_empty", rd_if.FIFO_EMPTY, 0);
        chk("clr_pre_busy", BUSY, 1);
        CLEAR = 1'b1;
        TRIG = 1'b1;
        TRIG_ID = 32'h8;
        step();
        CLEAR = 1'b0;
        TRIG = 1'b0;
        chk("clr_empty", rd_if.FIFO_EMPTY, 1);
        chk("clr_lost", LOST_CNT, 0);
        chk("clr_busy", BUSY, 0);
        step(2);
        chk("clr_trig_discarded", rd_if.FIFO_EMPTY, 1);
        fire(32'h9, 64'h9);
        step();
        chk("clr_next_w0", rd_if.FIFO_DATA, 32'h8000_0009);
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;

        // full stall with no reads
        exp_q.delete();
        for (int i = 1; i <= 3; i++) begin
            push_exp(i, {32'h1000_0000 + i, 32'h2000_0000 + i});
            fire(i, {32'h1000_0000 + i, 32'h2000_0000 + i});
            step(9);
        end
        chk("full_flag", rd_if.FIFO_FULL, 1);
        chk("full_size", rd_if.FIFO_SIZE, 8);
        chk("full_busy", BUSY, 1);
        rd_word("full_w0", exp_q[0]);
        step(10);
        chk("full_size_after_pop", rd_if.FIFO_SIZE, 8);
        for (int i = 1; i <= 8; i++) rd_word($sformatf("full_seq%0d", i), exp_q[i]);
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;

        // saturating lost counter
        TRIG = 1'b1;
        TRIG_ID = 32'h42;
        step(320);
        TRIG = 1'b0;
        step();
        chk("sat_lost", LOST_CNT, 8'hFF);
        chk("sat_full", rd_if.FIFO_FULL, 1);
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        chk("sat_clear_lost", LOST_CNT, 0);
        chk("sat_clear_empty", rd_if.FIFO_EMPTY, 1);

        // read while empty leaves pointers alone
        rd_if.FIFO_READ = 1'b1;
        step(2);
        rd_if.FIFO_READ = 1'b0;
        chk("rd_empty_size", rd_if.FIFO_SIZE, 0);
        fire(32'hC, 64'hC);
        step();
        chk("rd_empty_next_w0", rd_if.FIFO_DATA, 32'h8000_000C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/tlu_trigger_fifo.md
Name: tlu_trigger_fifo

Overview:
- Downstream data stage of the TLU master core: captures trigger ID, 64-bit time stamp and leading-edge diagnostics on every generated trigger pulse.
- Packs each event into 32-bit words and buffers them in a first-word-fall-through FIFO.
- The bus/readout side drains the FIFO through FIFO_READ/FIFO_EMPTY/FIFO_DATA.
- Single clock domain, CLK40, the same domain that produces the trigger pulse and counters.

Parameters:
- DEPTH, 1024: FIFO depth in 32-bit words; power of two, minimum 8.
- ADDR_W, 10: log2(DEPTH); must be consistent with DEPTH.

Ports:
- CLK40  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CLEAR  in  1  synchronous flush: empties FIFO, holding register and serializer, and zeroes LOST_CNT.
- ENABLE  in  1  when low, TRIG is ignored and not counted as lost.
- TRIG  in  1  single-cycle trigger pulse (GEN_TRIG_PULSE).
- TRIG_ID  in  32  trigger number, valid in the TRIG cycle.
- TIME_STAMP  in  64  time stamp, valid in the TRIG cycle.
- LE_DISTANCE  in  8  leading-edge spread of the trigger.
- SKIP_CNT  in  8  skipped-trigger counter snapshot.
- FIFO_READ  in  1  pop strobe; ignored while FIFO_EMPTY is high.
- FIFO_EMPTY  out  1  high when no word is stored.
- FIFO_FULL  out  1  high when DEPTH words are stored.
- FIFO_DATA  out  32  head word; valid while FIFO_EMPTY is low.
- FIFO_SIZE  out  ADDR_W+1  current word count.
- LOST_CNT  out  8  saturating count of dropped events.
- BUSY  out  1  serializer not IDLE or holding register valid.

Behaviour:
- Reset (RST_N low, asynchronous):
  - FIFO_EMPTY=1, FIFO_FULL=0, FIFO_SIZE=0, FIFO_DATA=0.
  - LOST_CNT=0, BUSY=0, state=IDLE, holding register empty.
- Event words (base set, 3 per event):
  - W0 = {1'b1, TRIG_ID[30:0]}.
  - W1 = TIME_STAMP[31:0].
  - W2 = TIME_STAMP[63:32].
  - Bit 31 of W0 is the event marker. W1 and W2 may have bit 31 set; the reader aligns on the word count.
- Acceptance: a trigger is accepted at edge e when TRIG & ENABLE & !CLEAR.
  - All inputs are latched at that edge.
- Serializer FSM states: IDLE, W0, W1, W2 (plus W3 with the optional feature).
  - IDLE: an accepted trigger is latched into the event register; next state W0.
  - Wn: if FIFO not full, write the word and advance. If full, stay in Wn; no word is dropped or duplicated.
  - After the last word: if holding is valid, move holding into the event register and go to W0; otherwise go to IDLE.
- Holding register (1 entry):
  - A trigger accepted while state≠IDLE goes to holding if holding is empty or is being transferred at that same edge.
  - Otherwise the event is dropped and LOST_CNT increments, saturating at 8'hFF.
- Latency: TRIG sampled at edge e0 → W0 written at e1 → FIFO_EMPTY low after e1. W1 and W2 follow at e2 and e3 when the FIFO is not full.
- FIFO:
  - FWFT: FIFO_DATA always shows the oldest word.
  - FIFO_READ with !FIFO_EMPTY pops at the edge.
  - A simultaneous write and pop leaves FIFO_SIZE unchanged.
  - Write and pop are both allowed while full; the pop frees the slot and the write lands in the same edge.
  - Pointers are ADDR_W bits and wrap modulo DEPTH; FIFO_SIZE = wr_count − rd_count.
- CLEAR:
  - Has priority over everything: FIFO is flushed, FSM goes to IDLE, holding is emptied, LOST_CNT is zeroed.
  - A TRIG in the CLEAR cycle is discarded and not counted.
  - A partially written event is truncated; the flush removes its words.
- FIFO_READ while empty: no pointer change, no error.

Optional Feature:
- Macro: TLU_TRIGGER_FIFO_DIAG_WORD_EN.
- Defined:
  - A fourth word per event, W3 = {8'hA5, 8'h00, SKIP_CNT, LE_DISTANCE}, is written after W2 through state W3.
  - Events are 4 words; all latency and holding rules extend accordingly.
- Undefined: events are 3 words, state W3 does not exist, and LE_DISTANCE/SKIP_CNT are unused.

Test Plan:
- Single trigger: TRIG_ID=32'h0000_0005, TIME_STAMP=64'h0000_0001_0000_00A0 → FIFO_EMPTY falls one edge after capture; reads give 32'h8000_0005, 32'h0000_00A0, 32'h0000_0001; FIFO_SIZE returns to 0.
- Burst: TRIG on 3 consecutive cycles → events 1 and 2 stored (holding), third dropped; LOST_CNT=1; FIFO_SIZE=6 after settling.
- Full stall: DEPTH=8, no reads, 3 triggers spaced 10 cycles → 8 words stored, FSM stalls, FIFO_FULL=1. Reading 1 word lets the stalled word in; no duplicates, sequence intact.
- CLEAR mid-event: CLEAR asserted while the FSM is in W1, with TRIG in the same cycle → FIFO_EMPTY=1, LOST_CNT=0, BUSY=0 next cycle; the next trigger produces a clean W0.
- Saturation and enable:
  - ENABLE=0 with 5 TRIGs → nothing written, LOST_CNT unchanged.
  - 300 forced drops → LOST_CNT=8'hFF.
- Diagnostic word (macro defined): LE_DISTANCE=8'h03, SKIP_CNT=8'h02 → fourth word 32'hA500_0203, 4 words per event.
